// File: rtl/mem_access_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mem_access_ctrl
// Purpose  : Load/store access controller between an RV32I pipeline and a
//            request/grant memory bus. Captures one op at a time, positions
//            store data and byte strobes on the bus lanes, waits for grant
//            (and read data for loads), then emits a one-cycle rsp_valid.
//            Captured addr[1:0], funct3 and raw read word are exported for a
//            downstream read-data mask stage.
// Ports    : clk, rst                          clock / sync active-high reset
//            op_valid/op_ready/op_we/op_func3/
//            op_addr/op_wdata                   pipeline op handshake
//            ram_req/ram_gnt/ram_we/ram_addr/
//            ram_wdata/ram_wmask/ram_rvalid/
//            ram_rdata                          memory bus
//            rsp_valid, mem_raddr_index, mask_type, mem_read_data,
//            misalign_err                       completion / mask-stage info
// Config   : MEM_MISALIGN_TRAP_EN - when defined, misaligned ops complete
//            immediately with misalign_err = 1 and never touch the bus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef FUNC3_WIDTH
`define FUNC3_WIDTH 3
`endif

module mem_access_ctrl #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ADDR_WIDTH  = 32,
  parameter int FUNC3_WIDTH = `FUNC3_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic                   op_we,
  input  logic [FUNC3_WIDTH-1:0] op_func3,
  input  logic [ADDR_WIDTH-1:0]  op_addr,
  input  logic [DATA_WIDTH-1:0]  op_wdata,
  output logic                   ram_req,
  input  logic                   ram_gnt,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  output logic [3:0]             ram_wmask,
  input  logic                   ram_rvalid,
  input  logic [DATA_WIDTH-1:0]  ram_rdata,
  output logic                   rsp_valid,
  output logic [1:0]             mem_raddr_index,
  output logic [FUNC3_WIDTH-1:0] mask_type,
  output logic [DATA_WIDTH-1:0]  mem_read_data,
  output logic                   misalign_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t                 state_q;
  logic                   ram_req_q;
  logic                   ram_we_q;
  logic [ADDR_WIDTH-1:0]  ram_addr_q;
  logic [DATA_WIDTH-1:0]  ram_wdata_q;
  logic [3:0]             ram_wmask_q;
  logic                   rsp_valid_q;
  logic [1:0]             raddr_index_q;
  logic [FUNC3_WIDTH-1:0] mask_type_q;
  logic [DATA_WIDTH-1:0]  read_data_q;
  logic                   misalign_q;

  logic [1:0]             size_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [3:0]             wmask_d;
  logic                   misalign_d;
  logic                   accept_d;

  assign accept_d = op_valid && (state_q == IDLE);

  // Access size from funct3. funct3[2] marks the unsigned load variants
  // (LBU/LHU); for stores it has no meaning, so such codes fall to word.
  always_comb begin
    size_d = SZ_WORD;
    if (!op_we || !op_func3[2]) begin
      if (op_func3[1:0] == 2'b00)      size_d = SZ_BYTE;
      else if (op_func3[1:0] == 2'b01) size_d = SZ_HALF;
    end
  end

  // Lane positioning: data is replicated across every lane of its width so
  // the strobes alone select the written bytes.
  always_comb begin
    wdata_d = op_wdata;
    wmask_d = 4'b1111;
    case (size_d)
      SZ_BYTE: begin
        wdata_d = {4{op_wdata[7:0]}};
        wmask_d = 4'b0001 << op_addr[1:0];
      end
      SZ_HALF: begin
        wdata_d = {2{op_wdata[15:0]}};
        wmask_d = op_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_d = op_wdata;
        wmask_d = 4'b1111;
      end
    endcase
    if (!op_we) wmask_d = 4'b0000;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_d = ((size_d == SZ_HALF) && op_addr[0]) ||
                      ((size_d == SZ_WORD) && (op_addr[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_wmask_q   <= 4'b0000;
      rsp_valid_q   <= 1'b0;
      raddr_index_q <= 2'b00;
      mask_type_q   <= '0;
      read_data_q   <= '0;
      misalign_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            ram_we_q      <= op_we;
            ram_addr_q    <= {op_addr[ADDR_WIDTH-1:2], 2'b00};
            ram_wdata_q   <= wdata_d;
            ram_wmask_q   <= wmask_d;
            raddr_index_q <= op_addr[1:0];
            mask_type_q   <= op_func3;
            misalign_q    <= misalign_d;
            if (misalign_d) begin
              // Trapped access: complete at once without a bus request.
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              ram_req_q <= 1'b1;
              state_q   <= REQ;
            end
          end
        end
        REQ: begin
          if (ram_gnt) begin
            ram_req_q <= 1'b0;
            if (ram_we_q) begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (ram_rvalid) begin
            read_data_q <= ram_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign op_ready        = (state_q == IDLE);
  assign ram_req         = ram_req_q;
  assign ram_we          = ram_we_q;
  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign ram_wmask       = ram_wmask_q;
  assign rsp_valid       = rsp_valid_q;
  assign mem_raddr_index = raddr_index_q;
  assign mask_type       = mask_type_q;
  assign mem_read_data   = read_data_q;
  assign misalign_err    = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl. Inputs change
//            1 time unit after each rising edge; outputs are checked at the
//            same point, once the registers have settled.
// Config   : MEM_MISALIGN_TRAP_EN selects the expectations for the
//            misaligned-load step.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic        op_we;
  logic [2:0]  op_func3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        ram_req;
  logic        ram_gnt;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wmask;
  logic        ram_rvalid;
  logic [31:0] ram_rdata;
  logic        rsp_valid;
  logic [1:0]  mem_raddr_index;
  logic [2:0]  mask_type;
  logic [31:0] mem_read_data;
  logic        misalign_err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .FUNC3_WIDTH(3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_we          (op_we),
    .op_func3       (op_func3),
    .op_addr        (op_addr),
    .op_wdata       (op_wdata),
    .ram_req        (ram_req),
    .ram_gnt        (ram_gnt),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_wmask      (ram_wmask),
    .ram_rvalid     (ram_rvalid),
    .ram_rdata      (ram_rdata),
    .rsp_valid      (rsp_valid),
    .mem_raddr_index(mem_raddr_index),
    .mask_type      (mask_type),
    .mem_read_data  (mem_read_data),
    .misalign_err   (misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    op_valid = 1'b1;
    op_we    = we;
    op_func3 = f3;
    op_addr  = addr;
    op_wdata = wd;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_func3 = 3'b000;
    op_addr = 32'h0; op_wdata = 32'h0; ram_gnt = 1'b0;
    ram_rvalid = 1'b0; ram_rdata = 32'h0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_op_ready", {31'b0, op_ready}, 32'd1);
    check("rst_ram_req",  {31'b0, ram_req}, 32'd0);
    check("rst_ram_we",   {31'b0, ram_we}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_ram_wmask", {28'b0, ram_wmask}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_raddr_idx", {30'b0, mem_raddr_index}, 32'd0);
    check("rst_mask_type", {29'b0, mask_type}, 32'd0);
    check("rst_rdata",    mem_read_data, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);

    // SW 0x100, immediate grant: rsp_valid two cycles after accept
    ram_gnt = 1'b1;
    present(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    op_valid = 1'b0;
    check("sw_req",     {31'b0, ram_req}, 32'd1);
    check("sw_we",      {31'b0, ram_we}, 32'd1);
    check("sw_addr",    ram_addr, 32'h0000_0100);
    check("sw_wmask",   {28'b0, ram_wmask}, 32'hF);
    check("sw_wdata",   ram_wdata, 32'hDEAD_BEEF);
    check("sw_ready_busy", {31'b0, op_ready}, 32'd0);
    check("sw_rsp_early",  {31'b0, rsp_valid}, 32'd0);
    tick();
    check("sw_rsp",     {31'b0, rsp_valid}, 32'd1);
    check("sw_req_drop", {31'b0, ram_req}, 32'd0);
    tick();
    check("sw_rsp_end", {31'b0, rsp_valid}, 32'd0);
    check("sw_ready",   {31'b0, op_ready}, 32'd1);

    // SB 0x103: byte replicated, strobe on lane 3
    present(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    tick();
    op_valid = 1'b0;
    check("sb_addr",  ram_addr, 32'h0000_0100);
    check("sb_wmask", {28'b0, ram_wmask}, 32'h8);
    check("sb_wdata", ram_wdata, 32'hA5A5_A5A5);
    check("sb_idx",   {30'b0, mem_raddr_index}, 32'd3);
    check("sb_type",  {29'b0, mask_type}, 32'd0);
    tick();
    check("sb_rsp", {31'b0, rsp_valid}, 32'd1);
    tick();

    // SH 0x102: upper halfword lanes
    present(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF);
    tick();
    op_valid = 1'b0;
    check("sh_wmask", {28'b0, ram_wmask}, 32'hC);
    check("sh_wdata", ram_wdata, 32'hBEEF_BEEF);
    tick(); tick();

    // LH 0x202: grant held off 3 cycles, read data 2 cycles after grant
    ram_gnt = 1'b0;
    present(1'b0, 3'b001, 32'h0000_0202, 32'hFFFF_FFFF);
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("lh_req_held", {31'b0, ram_req}, 32'd1);
      check("lh_wmask0",   {28'b0, ram_wmask}, 32'h0);
      tick();
    end
    ram_gnt = 1'b1;
    check("lh_req_4th", {31'b0, ram_req}, 32'd1);
    check("lh_addr",    ram_addr, 32'h0000_0200);
    tick();
    ram_gnt = 1'b0;
    check("lh_req_drop", {31'b0, ram_req}, 32'd0);
    check("lh_no_rsp",   {31'b0, rsp_valid}, 32'd0);
    tick();
    check("lh_wait_rsp", {31'b0, rsp_valid}, 32'd0);
    ram_rvalid = 1'b1; ram_rdata = 32'h8001_1234;
    tick();
    ram_rvalid = 1'b0;
    check("lh_rsp",   {31'b0, rsp_valid}, 32'd1);
    check("lh_rdata", mem_read_data, 32'h8001_1234);
    check("lh_idx",   {30'b0, mem_raddr_index}, 32'd2);
    check("lh_type",  {29'b0, mask_type}, 32'd1);
    tick();
    check("lh_rsp_single", {31'b0, rsp_valid}, 32'd0);

    // rvalid while idle is ignored
    ram_rvalid = 1'b1; ram_rdata = 32'hFFFF_FFFF;
    tick();
    ram_rvalid = 1'b0;
    check("idle_rvalid_data", mem_read_data, 32'h8001_1234);
    check("idle_rvalid_rsp",  {31'b0, rsp_valid}, 32'd0);

    // Reset while in REQ drops ram_req
    present(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    tick();
    op_valid = 1'b0;
    check("rreq_req", {31'b0, ram_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rreq_req_drop", {31'b0, ram_req}, 32'd0);
    check("rreq_ready",    {31'b0, op_ready}, 32'd1);

    // Reset in WAIT_R, then a stale rvalid
    ram_gnt = 1'b1;
    present(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    tick();
    op_valid = 1'b0;
    tick();
    ram_gnt = 1'b0;
    check("rwait_in_wait", {31'b0, op_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rwait_ready", {31'b0, op_ready}, 32'd1);
    check("rwait_req",   {31'b0, ram_req}, 32'd0);
    check("rwait_rdata", mem_read_data, 32'h0);
    ram_rvalid = 1'b1; ram_rdata = 32'h1234_5678;
    tick();
    ram_rvalid = 1'b0;
    check("stale_rsp",   {31'b0, rsp_valid}, 32'd0);
    check("stale_rdata", mem_read_data, 32'h0);

    // Misaligned LW 0x301
    ram_gnt = 1'b1;
    present(1'b0, 3'b010, 32'h0000_0301, 32'h0);
    tick();
    op_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_no_req",   {31'b0, ram_req}, 32'd0);
    check("mis_rsp",      {31'b0, rsp_valid}, 32'd1);
    check("mis_err",      {31'b0, misalign_err}, 32'd1);
    check("mis_rdata",    mem_read_data, 32'h0);
    tick();
    check("mis_rsp_end",  {31'b0, rsp_valid}, 32'd0);
`else
    check("mis_req",  {31'b0, ram_req}, 32'd1);
    check("mis_addr", ram_addr, 32'h0000_0300);
    check("mis_err0", {31'b0, misalign_err}, 32'd0);
    tick();
    ram_gnt = 1'b0;
    ram_rvalid = 1'b1; ram_rdata = 32'hCAFE_F00D;
    tick();
    ram_rvalid = 1'b0;
    check("mis_rsp",   {31'b0, rsp_valid}, 32'd1);
    check("mis_rdata", mem_read_data, 32'hCAFE_F00D);
    check("mis_idx",   {30'b0, mem_raddr_index}, 32'd1);
    check("mis_err1",  {31'b0, misalign_err}, 32'd0);
    tick();
`endif
    ram_gnt = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
